// File: rtl/mux_6to1.sv
// Six-lane selector with a combinational output, a registered copy and a registered illegal-select flag.
// Define MUX_6TO1_ERR_STICKY_EN to make sel_err hold until reset; otherwise it tracks the last sampled select.
module mux_6to1 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6*WIDTH-1:0]   i,
    input  logic [2:0]           s,
    output logic [WIDTH-1:0]     y,
    output logic [WIDTH-1:0]     y_q,
    output logic                 sel_err
);

    logic illegal_sel;

    assign illegal_sel = (s >= 3'd6);

    // Only the addressed lane reaches y, so X on unselected lanes cannot leak through.
    always_comb begin
        y = '0;
        case (s)
            3'd0:    y = i[0*WIDTH +: WIDTH];
            3'd1:    y = i[1*WIDTH +: WIDTH];
            3'd2:    y = i[2*WIDTH +: WIDTH];
            3'd3:    y = i[3*WIDTH +: WIDTH];
            3'd4:    y = i[4*WIDTH +: WIDTH];
            3'd5:    y = i[5*WIDTH +: WIDTH];
            default: y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
`ifdef MUX_6TO1_ERR_STICKY_EN
            if (illegal_sel) begin
                sel_err <= 1'b1;
            end
`else
            sel_err <= illegal_sel;
`endif
        end
    end

endmodule

// File: tb/tb_mux_6to1.sv
// Directed bench for mux_6to1: one WIDTH=1 and one WIDTH=8 instance share clock, reset and select.
// Expected sel_err values follow MUX_6TO1_ERR_STICKY_EN when the bench is built with it.
module tb_mux_6to1;

    logic        clk;
    logic        rst_n;
    logic [5:0]  i1;
    logic [47:0] i8;
    logic [2:0]  s;
    logic        y1;
    logic        y_q1;
    logic        sel_err1;
    logic [7:0]  y8;
    logic [7:0]  y_q8;
    logic        sel_err8;

    int vectors;
    int miscompares;
    logic sticky;

    mux_6to1 #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i1),
        .s       (s),
        .y       (y1),
        .y_q     (y_q1),
        .sel_err (sel_err1)
    );

    mux_6to1 #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i8),
        .s       (s),
        .y       (y8),
        .y_q     (y_q8),
        .sel_err (sel_err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge, well away from the sampling edge.
    task automatic applyStimulus(input logic [2:0] sel, input logic [5:0] lanes1, input logic [47:0] lanes8);
        @(negedge clk);
        s  = sel;
        i1 = lanes1;
        i8 = lanes8;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s miscompare", tag);
        end
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    localparam logic [47:0] LANES8 = {8'h65, 8'h54, 8'h43, 8'h32, 8'h21, 8'h10};

    initial begin
        vectors     = 0;
        miscompares = 0;
`ifdef MUX_6TO1_ERR_STICKY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        rst_n = 1'b0;
        s     = 3'd0;
        i1    = 6'b0;
        i8    = 48'b0;
        #2;
        checkOutput("reset_y_q1", {7'b0, y_q1}, 8'h00);
        checkOutput("reset_sel_err1", {7'b0, sel_err1}, 8'h00);
        checkOutput("reset_y_q8", y_q8, 8'h00);
        nextEdge();
        checkOutput("reset_hold_y_q1", {7'b0, y_q1}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] one-hot walk");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'(k), 6'(1 << k), 48'b0);
            checkOutput($sformatf("walk_y_s%0d", k), {7'b0, y1}, 8'h01);
            nextEdge();
            checkOutput($sformatf("walk_y_q_s%0d", k), {7'b0, y_q1}, 8'h01);
            checkOutput($sformatf("walk_err_s%0d", k), {7'b0, sel_err1}, 8'h00);
        end

        $display("[TB] inverted selection");
        applyStimulus(3'd0, 6'b111110, 48'b0);
        checkOutput("inv_y_s0", {7'b0, y1}, 8'h00);
        nextEdge();
        checkOutput("inv_y_q_s0", {7'b0, y_q1}, 8'h00);
        for (int k = 1; k < 6; k++) begin
            applyStimulus(3'(k), 6'b111110, 48'b0);
            checkOutput($sformatf("inv_y_s%0d", k), {7'b0, y1}, 8'h01);
        end

        $display("[TB] illegal select");
        applyStimulus(3'd6, 6'b111111, LANES8);
        checkOutput("ill_y_s6", {7'b0, y1}, 8'h00);
        checkOutput("ill_y8_s6", y8, 8'h00);
        nextEdge();
        checkOutput("ill_err_s6", {7'b0, sel_err1}, 8'h01);
        checkOutput("ill_y_q_s6", {7'b0, y_q1}, 8'h00);
        checkOutput("ill_err8_s6", {7'b0, sel_err8}, 8'h01);
        applyStimulus(3'd7, 6'b111111, LANES8);
        checkOutput("ill_y_s7", {7'b0, y1}, 8'h00);
        nextEdge();
        checkOutput("ill_err_s7", {7'b0, sel_err1}, 8'h01);
        checkOutput("ill_y_q_s7", {7'b0, y_q1}, 8'h00);

        $display("[TB] error clear");
        applyStimulus(3'd2, 6'b111111, LANES8);
        checkOutput("clr_y_s2", {7'b0, y1}, 8'h01);
        checkOutput("clr_err_before_edge", {7'b0, sel_err1}, 8'h01);
        for (int c = 0; c < 3; c++) begin
            nextEdge();
            checkOutput($sformatf("clr_err_c%0d", c), {7'b0, sel_err1}, {7'b0, sticky});
            checkOutput($sformatf("clr_y_q_c%0d", c), {7'b0, y_q1}, 8'h01);
        end

        $display("[TB] asynchronous reset");
        applyStimulus(3'd6, 6'b111111, LANES8);
        nextEdge();
        applyStimulus(3'd0, 6'b111111, LANES8);
        nextEdge();
        checkOutput("arst_pre_y_q", {7'b0, y_q1}, 8'h01);
        checkOutput("arst_pre_err", {7'b0, sel_err1}, {7'b0, sticky});
        checkOutput("arst_pre_y_q8", y_q8, 8'h10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_y_q", {7'b0, y_q1}, 8'h00);
        checkOutput("arst_err", {7'b0, sel_err1}, 8'h00);
        checkOutput("arst_y_q8", y_q8, 8'h00);
        checkOutput("arst_y_live", {7'b0, y1}, 8'h01);
        checkOutput("arst_y8_live", y8, 8'h10);
        s = 3'd7;
        nextEdge();
        checkOutput("arst_hold_y_q", {7'b0, y_q1}, 8'h00);
        checkOutput("arst_hold_err", {7'b0, sel_err1}, 8'h00);
        checkOutput("arst_y_live_s7", {7'b0, y1}, 8'h00);
        applyStimulus(3'd3, 6'b001000, LANES8);
        rst_n = 1'b1;
        nextEdge();
        checkOutput("rel_y_q", {7'b0, y_q1}, 8'h01);
        checkOutput("rel_err", {7'b0, sel_err1}, 8'h00);
        checkOutput("rel_y_q8", y_q8, 8'h43);

        $display("[TB] width 8");
        applyStimulus(3'd4, 6'b0, LANES8);
        checkOutput("w8_y_s4", y8, 8'h54);
        nextEdge();
        checkOutput("w8_y_q_s4", y_q8, 8'h54);
        applyStimulus(3'd5, 6'b0, LANES8);
        checkOutput("w8_y_s5", y8, 8'h65);
        checkOutput("w8_y_q_still_s4", y_q8, 8'h54);
        nextEdge();
        checkOutput("w8_y_q_s5", y_q8, 8'h65);
        applyStimulus(3'd1, 6'b0, LANES8);
        checkOutput("w8_y_s1", y8, 8'h21);
        applyStimulus(3'd7, 6'b0, LANES8);
        checkOutput("w8_y_s7", y8, 8'h00);
        nextEdge();
        checkOutput("w8_y_q_s7", y_q8, 8'h00);
        checkOutput("w8_err_s7", {7'b0, sel_err8}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
